// File: rtl/reg_file_pkg.sv
// Shared widths, the hardwired-zero index and the register word type for reg_file.
package reg_file_pkg;

  localparam int N_BITS    = 32;
  localparam int ADDR_BITS = 5;
  localparam int ZERO_REG  = 0;

  typedef logic [N_BITS-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: index mux, $zero masking, write bypass under REGFILE_BYPASS_EN.
// Zero-cycle latency, no flow control.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int n = N_BITS,
  parameter int r = ADDR_BITS
) (
  input  logic [2**r-1:0][n-1:0] regs,
  input  logic [r-1:0]           addr,
  input  logic [r-1:0]           write_addr,
  input  logic [n-1:0]           write_data,
  input  logic                   write_en,
  output logic [n-1:0]           data
);

  logic addr_is_zero;
  assign addr_is_zero = (addr == r'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  // A nonzero read address implies a nonzero write address whenever they match.
  logic bypass_hit;
  assign bypass_hit = write_en && (addr == write_addr);

  always_comb begin
    data = regs[addr];
    if (addr_is_zero) begin
      data = '0;
    end else if (bypass_hit) begin
      data = write_data;
    end
  end
`else
  logic unused_write_side;
  assign unused_write_side = ^{write_addr, write_data, write_en};

  always_comb begin
    data = regs[addr];
    if (addr_is_zero) begin
      data = '0;
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// 2**r x n register file, two async reads, one sync write, $zero hardwired; reads have zero latency.
// Define REGFILE_BYPASS_EN to forward write_data to a matching read port before the edge.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int n = N_BITS,
  parameter int r = ADDR_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [r-1:0] read_addr1,
  input  logic [r-1:0] read_addr2,
  input  logic [r-1:0] write_addr,
  input  logic [n-1:0] write_data,
  input  logic         write_en,
  output logic [n-1:0] read_data1,
  output logic [n-1:0] read_data2
);

  logic [2**r-1:0][n-1:0] regs;
  logic                   write_ok;

  assign write_ok = write_en && (write_addr != r'(ZERO_REG));

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else if (write_ok) begin
      regs[write_addr] <= write_data;
    end
  end

  reg_file_read_port #(.n(n), .r(r)) u_port1 (
    .regs       (regs),
    .addr       (read_addr1),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en),
    .data       (read_data1)
  );

  reg_file_read_port #(.n(n), .r(r)) u_port2 (
    .regs       (regs),
    .addr       (read_addr2),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en),
    .data       (read_data2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed-vector bench for reg_file; expected values are hand-computed constants.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr1, read_addr2, write_addr;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] read_data1, read_data2;

  int vectors = 0;
  int miscompares = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_7 = 32'h0000_0055;
`else
  localparam logic [31:0] SAME_CYCLE_7 = 32'h0000_0000;
`endif

  reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    read_addr1 = 5'd0;
    read_addr2 = 5'd3;
    write_addr = 5'd0;
    write_data = 32'h0;
    write_en   = 1'b0;
    #3;
    check("reset_rd1_a0", read_data1, 32'h0);
    check("reset_rd2_a3", read_data2, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Basic write then overwrite of register 6
    write_addr = 5'd6; write_data = 32'hA7; write_en = 1'b1; read_addr1 = 5'd6;
    tick();
    check("wr6_first", read_data1, 32'hA7);
    write_data = 32'h23;
    tick();
    check("wr6_overwrite", read_data1, 32'h23);

    // write_en low must not store
    write_en = 1'b0; write_addr = 5'd5; write_data = 32'h15; read_addr2 = 5'd5;
    tick();
    check("we0_reg5", read_data2, 32'h0);
    write_en = 1'b1;
    tick();
    check("we1_reg5", read_data2, 32'h15);
    check("reg6_kept", read_data1, 32'h23);

    // Writes to $zero are discarded
    write_addr = 5'd0; write_data = 32'hFFFF_FFFF; read_addr1 = 5'd0;
    #1;
    check("zero_pre_edge", read_data1, 32'h0);
    tick();
    check("zero_edge1", read_data1, 32'h0);
    tick();
    check("zero_edge2", read_data1, 32'h0);
    write_en = 1'b0;

    // Independent ports, no clock needed for address changes
    read_addr1 = 5'd5; read_addr2 = 5'd5;
    #2;
    check("dual_p1_r5", read_data1, 32'h15);
    check("dual_p2_r5", read_data2, 32'h15);
    read_addr2 = 5'd6;
    #2;
    check("p2_switch_r6", read_data2, 32'h23);
    check("p1_still_r5", read_data1, 32'h15);

    // Top address
    tick();
    write_addr = 5'd31; write_data = 32'hDEAD_BEEF; write_en = 1'b1;
    tick();
    write_en = 1'b0; read_addr2 = 5'd31;
    #1;
    check("reg31", read_data2, 32'hDEAD_BEEF);

    // Read-during-write on register 7
    tick();
    write_addr = 5'd7; write_data = 32'h55; write_en = 1'b1;
    read_addr1 = 5'd7; read_addr2 = 5'd6;
    #1;
    check("rdw_p1_pre_edge", read_data1, SAME_CYCLE_7);
    check("rdw_p2_other", read_data2, 32'h23);
    tick();
    write_en = 1'b0;
    #1;
    check("rdw_p1_post_edge", read_data1, 32'h55);

    // Asynchronous reset mid-cycle, with a write attempted while held
    read_addr1 = 5'd6; read_addr2 = 5'd7;
    #1;
    rst = 1'b0;
    #1;
    check("arst_rd1_r6", read_data1, 32'h0);
    check("arst_rd2_r7", read_data2, 32'h0);
    write_addr = 5'd9; write_data = 32'h99; write_en = 1'b1;
    tick();
    write_en = 1'b0; read_addr1 = 5'd9; read_addr2 = 5'd31;
    #1;
    check("arst_wr_blocked", read_data1, 32'h0);
    check("arst_rd2_r31", read_data2, 32'h0);
    rst = 1'b1;
    tick();
    read_addr1 = 5'd5; read_addr2 = 5'd6;
    #1;
    check("post_rst_r5", read_data1, 32'h0);
    check("post_rst_r6", read_data2, 32'h0);
    read_addr1 = 5'd9;
    #1;
    check("post_rst_r9", read_data1, 32'h0);

    // Writes work again after reset release
    write_addr = 5'd9; write_data = 32'h1234_5678; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    #1;
    check("post_rst_wr9", read_data1, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
